key_write_scheduler: RTL
========================

KEY_WRITE_SCHEDULER -- requirements
Module: key_write_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of key requesters (2..8).
REQ-002 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency.
REQ-003 SHALL have parameter TICK_HZ, default 10, clear-tick rate; DIV = CLK_HZ/TICK_HZ, integer, >= 4.
REQ-004 SHALL have port CLOCK50M  in  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req  in  NUM_REQ  per-requester key-write request, level.
REQ-007 SHALL have port req_key  in  8*NUM_REQ  packed key codes; requester i at bits [8i+7:8i].
REQ-008 SHALL have port ack  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
REQ-009 SHALL have port write  out  1  key-register write strobe.
REQ-010 SHALL have port address  out  2  key-register address; 2'b00 during write, else 2'b00.
REQ-011 SHALL have port user_input  out  8  key code to key register.
REQ-012 SHALL have port clock10h  out  1  one-cycle clear tick, every DIV cycles.
REQ-013 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-014 SHALL have port grant_id  out  $clog2(NUM_REQ)  index of last granted requester.

Function
REQ-015 SHALL free-run a 0..DIV-1 counter; clock10h = 1 exactly when counter == DIV-1, then counter wraps to 0.
REQ-016 SHALL implement FSM states IDLE, WRITE, HOLD.
REQ-017 IDLE: if any req bit set, SHALL select round-robin, starting at (grant_id+1) mod NUM_REQ, register its key and index, go to WRITE; else stay IDLE.
REQ-018 WRITE: SHALL assert write=1, address=2'b00, user_input=registered key and ack[grant_id]=1 for exactly one cycle, then go to HOLD.
REQ-019 Latency: req sampled high in IDLE at edge n SHALL yield write/ack in cycle n+1.
REQ-020 HOLD: SHALL stay until the first clock10h strictly after the WRITE cycle, then go to IDLE on that tick's edge.
REQ-021 If clock10h coincides with the WRITE cycle, that tick SHALL NOT end HOLD; the next tick does (key visible >= one full period).
REQ-022 Outside WRITE, write SHALL be 0, ack SHALL be all-zero, and user_input SHALL hold the last written key.
REQ-023 Requests that drop before selection SHALL be ignored; req/req_key change after selection SHALL NOT affect the in-flight write.
REQ-024 At most one key SHALL be written per HOLD window; pending requesters wait, no request is lost while held high.

Reset
REQ-025 On reset_n low, asynchronously: state IDLE, tick counter 0, write 0, ack 0, address 2'b00, user_input 8'h00, clock10h 0, busy 0, grant_id NUM_REQ-1 (requester 0 wins first).
REQ-026 Reset asserted mid-WRITE or mid-HOLD SHALL abort the transfer with no ack issued after reset release until a fresh selection.

Configuration
REQ-027 Macro KEY_SCHED_ZERO_FILTER_EN defined: a selected request with key 8'h00 SHALL be acked in the cycle after selection with write=0, FSM returns to IDLE, grant_id advances.
REQ-028 Macro undefined: key 8'h00 SHALL be written and held like any other key.

Structure
REQ-029 Package key_sched_pkg SHALL hold the FSM state enum, KEY_W = 8 and ADDR_KEY = 2'b00.
REQ-030 Tick generation SHALL be a sub-module tick_divider (parameter DIV; ports CLOCK50M, reset_n, tick).

Verification (CLK_HZ=80, TICK_HZ=10, DIV=8, NUM_REQ=4)
REQ-031 Reset release, no req -> clock10h pulses at cycles 7, 15, 23; write, ack, busy stay 0.
REQ-032 req=4'b0010, key1=8'h41 at cycle 2 -> cycle 3 write=1, user_input=8'h41, ack=4'b0010, grant_id=1; busy until edge of tick at cycle 7.
REQ-033 req=4'b1111 held, keys 8'h10..8'h13 -> writes in order 8'h10, 8'h11, 8'h12, 8'h13, one per tick window, each acked once.
REQ-034 WRITE forced on cycle 7 (tick coincident) -> HOLD persists to tick at cycle 15, no second write before cycle 16.
REQ-035 reset_n low during HOLD after key 8'h55 -> user_input 8'h00, busy 0 immediately; no ack after release without new req.
REQ-036 With KEY_SCHED_ZERO_FILTER_EN, req0 key 8'h00 -> ack=4'b0001, write stays 0, next requester served without waiting a tick.

Source files
------------

// File: rtl/key_sched_pkg.sv
// Shared types and constants for the key write scheduler.
package key_sched_pkg;

    localparam int         KEY_W    = 8;
    localparam logic [1:0] ADDR_KEY = 2'b00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running 0..DIV-1 counter; tick is high during the DIV-1 cycle.
module tick_divider #(
    parameter int DIV = 8
) (
    input  logic CLOCK50M,
    input  logic reset_n,
    output logic tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge CLOCK50M or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/key_write_scheduler.sv
// Round-robin arbiter writing one requester key per clear-tick window.
// Optional build macro KEY_SCHED_ZERO_FILTER_EN: key 8'h00 is acked without a write.
module key_write_scheduler
    import key_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 10
) (
    input  logic                       CLOCK50M,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_key,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       write,
    output logic [1:0]                 address,
    output logic [7:0]                 user_input,
    output logic                       clock10h,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int ID_W = $clog2(NUM_REQ);

    state_t             state_reg;
    logic               write_reg;
    logic [NUM_REQ-1:0] ack_reg;
    logic [KEY_W-1:0]   key_reg;
    logic               busy_reg;
    logic [ID_W-1:0]    grant_id_reg;

    logic               tick;
    logic [KEY_W-1:0]   key_arr [NUM_REQ];
    logic               sel_found;
    logic [ID_W-1:0]    sel_idx;
    logic [NUM_REQ-1:0] sel_onehot;
    logic [KEY_W-1:0]   sel_key;
    logic               zero_skip;
    int                 cand;

    tick_divider #(
        .DIV(DIV)
    ) u_tick (
        .CLOCK50M(CLOCK50M),
        .reset_n (reset_n),
        .tick    (tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_key
            assign key_arr[gi] = req_key[KEY_W*gi +: KEY_W];
        end
    endgenerate

    // Search begins one past the last winner so every held request is eventually served.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(grant_id_reg) + k) % NUM_REQ;
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(cand);
            end
        end
        sel_onehot = NUM_REQ'(1) << sel_idx;
        sel_key    = key_arr[sel_idx];
    end

`ifdef KEY_SCHED_ZERO_FILTER_EN
    assign zero_skip = (sel_key == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_ff @(posedge CLOCK50M or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            write_reg    <= 1'b0;
            ack_reg      <= '0;
            key_reg      <= '0;
            busy_reg     <= 1'b0;
            grant_id_reg <= ID_W'(NUM_REQ - 1);
        end else begin
            write_reg <= 1'b0;
            ack_reg   <= '0;
            case (state_reg)
                IDLE: begin
                    if (sel_found) begin
                        ack_reg      <= sel_onehot;
                        grant_id_reg <= sel_idx;
                        if (!zero_skip) begin
                            state_reg <= WRITE;
                            write_reg <= 1'b1;
                            key_reg   <= sel_key;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state_reg <= HOLD;
                end
                HOLD: begin
                    // Any tick seen here is strictly after the WRITE cycle.
                    if (tick) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign ack        = ack_reg;
    assign write      = write_reg;
    assign address    = ADDR_KEY;
    assign user_input = key_reg;
    assign clock10h   = tick;
    assign busy       = busy_reg;
    assign grant_id   = grant_id_reg;

endmodule
